// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of one single-port memory with req/ack handshake and access timeout.
// Optional macro ARB_RR_EN selects round-robin arbitration; default build is fixed priority (data over fetch).
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W     = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           r_state;
    logic             r_grant_d;
    logic [CNT_W-1:0] r_cnt;
    logic             w_any_req;
    logic             w_grant_d;
    logic             w_timeout;

`ifdef ARB_RR_EN
    logic r_last_d;

    // On a tie the port that did not win last time gets the memory.
    assign w_grant_d = d_req && (!i_req || !r_last_d);
`else
    assign w_grant_d = d_req;
`endif

    assign w_any_req = i_req || d_req;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // NOTE: every register below, including the read-data holding registers, is
    // cleared by rst so a reset mid-access leaves no stale pulse or captured data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant_d <= 1'b0;
            r_cnt     <= '0;
`ifdef ARB_RR_EN
            r_last_d  <= 1'b0;
`endif
            i_ready   <= 1'b0;
            i_rdata   <= '0;
            d_ready   <= 1'b0;
            d_rdata   <= '0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: non-blocking defaults make the ready/error outputs single-cycle pulses
            // without any extra clearing logic; later assignments in the case win.
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            bus_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_d <= w_grant_d;
`ifdef ARB_RR_EN
                        r_last_d  <= w_grant_d;
`endif
                        r_cnt     <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= w_grant_d ? d_we : 1'b0;
                        mem_addr  <= (w_grant_d ? d_addr : i_addr) & WORD_MASK;
                        mem_wdata <= w_grant_d ? d_wdata : '0;
                        r_state   <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    // An ack on the timeout cycle still counts as a good completion.
                    if (mem_ack || w_timeout) begin
                        mem_req <= 1'b0;
                        bus_err <= !mem_ack;
                        if (r_grant_d) begin
                            d_ready <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_ack ? mem_rdata : '0;
                            end
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_ack ? mem_rdata : '0;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Ready is visible during this cycle; the requester drops req before IDLE re-arbitrates.
                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single accesses plus hand-written
// sequences for arbitration, dropped requests, stray acks and reset mid-access.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          bus_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .bus_err  (bus_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mem_data;
        int            ack_at;      // ACCESS cycle index carrying mem_ack; -1 = never
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_i_rdata;
        logic [DW-1:0] exp_d_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access: raise the request, act as the memory, then watch for the ready pulse.
    task automatic do_access(input vec_t v, input string tag);
        int   lat;
        int   req_cycles;
        int   exp_lat;
        logic got;
        logic rdy_i;
        logic rdy_d;
        logic err;
        got = 1'b0; rdy_i = 1'b0; rdy_d = 1'b0; err = 1'b0;
        lat = -1; req_cycles = 0;
        i_req   = !v.is_d;
        i_addr  = v.addr;
        d_req   = v.is_d;
        d_we    = v.we;
        d_addr  = v.addr;
        d_wdata = v.wdata;
        tick();
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(v.exp_addr));
        check({tag, " mem_we"}, 64'(mem_we), 64'(v.we));
        if (v.we) check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(v.wdata));
        for (int c = 0; c < 16 && !got; c++) begin
            if (mem_req) req_cycles++;
            mem_ack   = (c == v.ack_at);
            mem_rdata = v.mem_data;
            tick();
            mem_ack = 1'b0;
            if (i_ready || d_ready) begin
                got = 1'b1; lat = c; rdy_i = i_ready; rdy_d = d_ready; err = bus_err;
            end
        end
        exp_lat = (v.ack_at < 0) ? TO - 1 : v.ack_at;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " mem_req cycles"}, 64'(req_cycles), 64'(exp_lat + 1));
        check({tag, " d_ready"}, 64'(rdy_d), 64'(v.is_d));
        check({tag, " i_ready"}, 64'(rdy_i), 64'(!v.is_d));
        check({tag, " bus_err"}, 64'(err), 64'(v.exp_err));
        check({tag, " i_rdata"}, 64'(i_rdata), 64'(v.exp_i_rdata));
        check({tag, " d_rdata"}, 64'(d_rdata), 64'(v.exp_d_rdata));
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        check({tag, " pulse end"}, 64'({i_ready, d_ready, bus_err, mem_req}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] first_addr;
        logic [AW-1:0] second_addr;
        logic          first_is_d;
        vec_t          v;

        // is_d we addr wdata mem_data ack_at exp_addr exp_i_rdata exp_d_rdata exp_err
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h2001_0005, 0, 32'h0000_0004, 32'h2001_0005, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_AAAA, 2, 32'h0000_0010, 32'h2001_0005, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 1, 32'h0000_0010, 32'h2001_0005, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h7777_7777, -1, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0022, 32'h0, 32'h1234_5678, 0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0024, 32'h0BAD_F00D, 32'hFFFF_0000, 3, 32'h0000_0024, 32'h0, 32'h1234_5678, 1'b0};

        #1;
        check("reset outputs", 64'({i_ready, d_ready, bus_err, mem_req, mem_we}), 64'(0));
        check("reset mem_addr", 64'(mem_addr), 64'(0));
        check("reset rdata", 64'({i_rdata, d_rdata}), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            do_access(vecs[k], $sformatf("vec%0d", k));
        end

        // Simultaneous requests; the previous grant went to data.
`ifdef ARB_RR_EN
        first_is_d = 1'b0;
`else
        first_is_d = 1'b1;
`endif
        first_addr  = first_is_d ? 32'h80 : 32'h40;
        second_addr = first_is_d ? 32'h40 : 32'h80;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        tick();
        check("tie first addr", 64'(mem_addr), 64'(first_addr));
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
        tick();
        mem_ack = 1'b0;
        check("tie first ready", 64'({i_ready, d_ready}), 64'(first_is_d ? 2'b01 : 2'b10));
        if (first_is_d) d_req = 1'b0; else i_req = 1'b0;
        tick();
        check("tie gap", 64'({i_ready, d_ready, mem_req}), 64'(0));
        tick();
        check("tie second addr", 64'(mem_addr), 64'(second_addr));
        check("tie second mem_req", 64'(mem_req), 64'(1));
        mem_ack = 1'b1; mem_rdata = 32'hBBBB_0002;
        tick();
        mem_ack = 1'b0;
        check("tie second ready", 64'({i_ready, d_ready}), 64'(first_is_d ? 2'b10 : 2'b01));
        check("tie rdata", 64'({i_rdata, d_rdata}), 64'({32'hBBBB_0002, 32'hAAAA_0001}) ^
              (first_is_d ? 64'(0) : {32'hBBBB_0002 ^ 32'hAAAA_0001, 32'hAAAA_0001 ^ 32'hBBBB_0002}));
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        // Data request dropped right after grant still completes exactly once.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        tick();
        check("drop granted", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h30}));
        d_req = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0D0D_0D0D;
        tick();
        mem_ack = 1'b0;
        check("drop ready", 64'({d_ready, i_ready, bus_err}), 64'(3'b100));
        check("drop rdata", 64'(d_rdata), 64'(32'h0D0D_0D0D));
        begin
            int extra;
            extra = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (mem_req || d_ready || i_ready) extra++;
            end
            check("drop no regrant", 64'(extra), 64'(0));
        end

        // An ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hEEEE_EEEE;
        tick();
        tick();
        mem_ack = 1'b0;
        check("stray ack", 64'({d_ready, i_ready, mem_req}), 64'(0));
        check("stray ack rdata", 64'(d_rdata), 64'(32'h0D0D_0D0D));

        // Reset asserted mid-access.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        tick();
        check("pre-reset mem_req", 64'(mem_req), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("async reset", 64'({mem_req, d_ready, i_ready, bus_err}), 64'(0));
        check("reset clears rdata", 64'(d_rdata), 64'(0));
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post-reset idle", 64'({mem_req, d_ready}), 64'(0));
        v = '{1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 1, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 1'b0};
        do_access(v, "after reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
